des_key_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one DES key-schedule pipeline among NUM_REQ requesters.
- Accepts a 64-bit key plus a mode bit from each requester and issues one key per cycle to the key generator.
- Tags every issued key with its requester id, routes the returned 768-bit round-key bundle back to that requester, and holds it until the requester accepts it.
- Sits between the per-channel DES cores and the key generator.

---
 rtl/des_key_arb.sv | 160 ++++++++++++++++
 tb/tb_des_key_arb.sv | 502 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_arb.sv
// des_key_arb: round-robin arbiter sharing one DES key-schedule pipeline among NUM_REQ requesters.
// Optional DES_KEY_ARB_CACHE_EN: per-requester last-key cache that bypasses the key generator on a hit.
module des_key_arb #(
    parameter int NUM_REQ = 2,
    parameter int ID_W = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [64*NUM_REQ-1:0]    req_key,
    input  logic [NUM_REQ-1:0]       req_dec,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     kg_valid,
    output logic [63:0]              kg_key,
    output logic                     kg_dec,
    input  logic                     kg_valid_i,
    input  logic [767:0]             kg_round_keys,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [768*NUM_REQ-1:0]   rsp_round_keys,
    output logic                     busy,
    output logic                     err
);
    localparam int CW = $clog2(NUM_REQ + 1);
    typedef enum logic [1:0] {IDLE, PEND, HOLD} slot_e;

    slot_e           slot_q [NUM_REQ];
    slot_e           slot_d [NUM_REQ];
    logic [767:0]    rk_q [NUM_REQ];
    logic [767:0]    rk_d [NUM_REQ];
    logic [ID_W-1:0] fifo_q [NUM_REQ];
    logic [ID_W-1:0] fifo_d [NUM_REQ];
    logic [ID_W-1:0] head_q, head_d, tail_q, tail_d, rr_q, rr_d, win;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [63:0]     kg_key_q, kg_key_d, key_w;
    logic            kg_valid_q, kg_valid_d, kg_dec_q, kg_dec_d, err_q, err_d;
    logic            found, hit, push, pop, dec_w;
    logic [NUM_REQ-1:0] elig;

    function automatic logic [ID_W-1:0] nxt(input logic [ID_W-1:0] p);
        return (p == ID_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    // Grant is gated by rst so every output reads 0 while reset is held.
    always_comb begin
        elig = '0;
        found = 1'b0;
        win = '0;
        for (int i = 0; i < NUM_REQ; i++) elig[i] = req_valid[i] && slot_q[i] == IDLE && !rst;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && elig[(int'(rr_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                win = ID_W'((int'(rr_q) + k) % NUM_REQ);
            end
        end
        req_ready = '0;
        if (found) req_ready[win] = 1'b1;
        key_w = req_key[64*win +: 64];
        dec_w = req_dec[win];
    end

`ifdef DES_KEY_ARB_CACHE_EN
    logic [63:0]        ck_q [NUM_REQ];
    logic [63:0]        ck_d [NUM_REQ];
    logic [NUM_REQ-1:0] cdec_q, cdec_d, cv_q, cv_d;
    assign hit = found && cv_q[win] && ck_q[win] == key_w && cdec_q[win] == dec_w;
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        push = found && !hit;
        pop = kg_valid_i && cnt_q != '0;
        rr_d = found ? nxt(win) : rr_q;
        kg_valid_d = push;
        kg_key_d = push ? key_w : kg_key_q;
        kg_dec_d = push ? dec_w : kg_dec_q;
        err_d = err_q | (kg_valid_i && cnt_q == '0);
        head_d = pop ? nxt(head_q) : head_q;
        tail_d = push ? nxt(tail_q) : tail_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        fifo_d = fifo_q;
        slot_d = slot_q;
        rk_d = rk_q;
        if (push) fifo_d[tail_q] = win;
        for (int i = 0; i < NUM_REQ; i++) if (slot_q[i] == HOLD && rsp_ready[i]) slot_d[i] = IDLE;
        if (found) slot_d[win] = hit ? HOLD : PEND;
        if (pop) begin
            slot_d[fifo_q[head_q]] = HOLD;
            rk_d[fifo_q[head_q]] = kg_round_keys;
        end
`ifdef DES_KEY_ARB_CACHE_EN
        ck_d = ck_q;
        cdec_d = cdec_q;
        cv_d = cv_q;
        // A miss invalidates the entry until its own bundle returns.
        if (push) begin
            ck_d[win] = key_w;
            cdec_d[win] = dec_w;
            cv_d[win] = 1'b0;
        end
        if (pop) cv_d[fifo_q[head_q]] = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_q[i] <= IDLE;
                rk_q[i] <= '0;
                fifo_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            rr_q <= '0;
            cnt_q <= '0;
            kg_valid_q <= 1'b0;
            kg_key_q <= '0;
            kg_dec_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            slot_q <= slot_d;
            rk_q <= rk_d;
            fifo_q <= fifo_d;
            head_q <= head_d;
            tail_q <= tail_d;
            rr_q <= rr_d;
            cnt_q <= cnt_d;
            kg_valid_q <= kg_valid_d;
            kg_key_q <= kg_key_d;
            kg_dec_q <= kg_dec_d;
            err_q <= err_d;
        end
    end

`ifdef DES_KEY_ARB_CACHE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) ck_q[i] <= '0;
            cdec_q <= '0;
            cv_q <= '0;
        end else begin
            ck_q <= ck_d;
            cdec_q <= cdec_d;
            cv_q <= cv_d;
        end
    end
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
        assign rsp_valid[g] = slot_q[g] == HOLD;
        assign rsp_round_keys[768*g +: 768] = rk_q[g];
    end

    assign kg_valid = kg_valid_q;
    assign kg_key = kg_key_q;
    assign kg_dec = kg_dec_q;
    assign err = err_q;
    assign busy = (cnt_q != '0) | (|rsp_valid) | kg_valid_q;
endmodule

// File: tb/tb_des_key_arb.sv
// tb_des_key_arb: directed and randomized checks of des_key_arb against a DES key-schedule stub and a queue-based model.
`timescale 1ns/1ps
module tb_des_key_arb;
    localparam int N = 2;
    localparam int IW = 1;
    localparam int PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                                60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                                29,21,13,5,28,20,12,4};
    localparam int PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    localparam int SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    typedef struct {int id; int due; logic [767:0] rk;} pend_t;

    logic clk = 0, rst = 0, inj = 0;
    logic [N-1:0] req_valid = '0, req_dec = '0, rsp_ready = '0, req_ready, rsp_valid;
    logic [64*N-1:0] req_key = '0;
    logic kg_valid, kg_dec, kg_valid_i, busy, err;
    logic [63:0] kg_key;
    logic [767:0] kg_round_keys;
    logic [768*N-1:0] rsp_round_keys;
    logic pv [4];
    logic [767:0] pk [4];
    int errors = 0, checks = 0, lat = 1;

    des_key_arb #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_key(req_key), .req_dec(req_dec),
        .req_ready(req_ready), .kg_valid(kg_valid), .kg_key(kg_key), .kg_dec(kg_dec),
        .kg_valid_i(kg_valid_i), .kg_round_keys(kg_round_keys), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_round_keys(rsp_round_keys), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [767:0] ks(input logic [63:0] key, input logic dec);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] k;
        logic [767:0] r;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1[i]];
        c = cd[55:28];
        d = cd[27:0];
        r = '0;
        for (int n = 0; n < 16; n++) begin
            for (int s = 0; s < SH[n]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2[i]];
            if (dec) r[48*n +: 48] = k;
            else r[767-48*n -: 48] = k;
        end
        return r;
    endfunction

    function automatic logic [767:0] rk(input int i);
        return rsp_round_keys[768*i +: 768];
    endfunction

    // Key generator stub: in-order pipeline of depth lat, shares the arbiter reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                pv[i] <= 1'b0;
                pk[i] <= '0;
            end
        end else begin
            pv[0] <= kg_valid;
            pk[0] <= ks(kg_key, kg_dec);
            for (int i = 1; i < 4; i++) begin
                pv[i] <= pv[i-1];
                pk[i] <= pk[i-1];
            end
        end
    end
    assign kg_valid_i = pv[lat-1] | inj;
    assign kg_round_keys = pk[lat-1];

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = '0;
        inj = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst = 1;
        #1;
        checks++;
        if ({req_ready, kg_valid, kg_dec, kg_key, rsp_valid, busy, err} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got %h expected 0", {req_ready, kg_valid, kg_dec, kg_key, rsp_valid, busy, err});
        end
        checks++;
        if (rsp_round_keys !== '0) begin
            errors++;
            $display("FAIL reset_rk: got nonzero bundle expected 0");
        end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        checks++;
        if ({req_ready, kg_valid, rsp_valid, busy, err} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got %h expected 0", {req_ready, kg_valid, rsp_valid, busy, err});
        end
    endtask

    task automatic test_single(input logic dec);
        logic [63:0] k = 64'h133457799BBCDFF1;
        logic [767:0] b;
        do_reset();
        lat = 1;
        req_key[63:0] = k;
        req_dec[0] = dec;
        req_valid[0] = 1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_grant: got %b expected 01", req_ready);
        end
        @(negedge clk);
        req_valid[0] = 0;
        checks++;
        if (kg_valid !== 1'b1 || kg_key !== k || kg_dec !== dec || rsp_valid !== '0) begin
            errors++;
            $display("FAIL single_issue: got v=%b key=%h dec=%b rv=%b expected v=1 key=%h dec=%b rv=00", kg_valid, kg_key, kg_dec, rsp_valid, k, dec);
        end
        @(negedge clk);
        checks++;
        if (kg_valid !== 1'b0 || rsp_valid !== '0) begin
            errors++;
            $display("FAIL single_t2: got kgv=%b rv=%b expected 0 00", kg_valid, rsp_valid);
        end
        @(negedge clk);
        b = rk(0);
        checks++;
        if (rsp_valid !== 2'b01 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_rsp: got rv=%b busy=%b expected 01 1", rsp_valid, busy);
        end
        checks++;
        if (b[767:720] !== (dec ? 48'hCB3D8B0E17F5 : 48'h1B02EFFC7072) ||
            b[47:0] !== (dec ? 48'h1B02EFFC7072 : 48'hCB3D8B0E17F5)) begin
            errors++;
            $display("FAIL single_keys dec=%b: got K1=%h K16=%h", dec, b[767:720], b[47:0]);
        end
        checks++;
        if (b !== ks(k, dec)) begin
            errors++;
            $display("FAIL single_bundle dec=%b: got %h expected %h", dec, b, ks(k, dec));
        end
        rsp_ready[0] = 1;
        @(negedge clk);
        rsp_ready = '0;
        checks++;
        if (rsp_valid !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_release: got rv=%b busy=%b expected 00 0", rsp_valid, busy);
        end
    endtask

    task automatic test_fairness();
        logic [63:0] gk [N];
        int nxt = 0, grants = 0, chg = -1, g;
        do_reset();
        lat = 1;
        rsp_ready = '1;
        req_dec = '0;
        for (int i = 0; i < N; i++) req_key[64*i +: 64] = {$urandom, $urandom};
        req_valid = '1;
        for (int c = 0; c < 24; c++) begin
            if (chg >= 0) req_key[64*chg +: 64] = {$urandom, $urandom};
            chg = -1;
            #1;
            for (int i = 0; i < N; i++) begin
                if (rsp_valid[i]) begin
                    checks++;
                    if (rk(i) !== ks(gk[i], 1'b0)) begin
                        errors++;
                        $display("FAIL fair_route req%0d: got %h expected %h", i, rk(i), ks(gk[i], 1'b0));
                    end
                end
            end
            if (req_ready != '0) begin
                checks++;
                if (req_ready !== (N'(1) << nxt)) begin
                    errors++;
                    $display("FAIL fair_order: got %b expected %b", req_ready, N'(1) << nxt);
                end
                g = 0;
                for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
                gk[g] = req_key[64*g +: 64];
                chg = g;
                grants++;
                nxt = (nxt + 1) % N;
            end
            @(negedge clk);
        end
        checks++;
        if (grants != 12) begin
            errors++;
            $display("FAIL fair_count: got %0d expected 12", grants);
        end
        req_valid = '0;
        repeat (4) @(negedge clk);
        rsp_ready = '0;
    endtask

    task automatic test_backpressure();
        logic [767:0] b;
        logic [63:0] k1;
        int w = 0, g0 = 0;
        do_reset();
        lat = 1;
        rsp_ready = 2'b01;
        req_dec = '0;
        for (int i = 0; i < N; i++) req_key[64*i +: 64] = {$urandom, $urandom};
        k1 = req_key[127:64];
        req_valid = '1;
        while (!rsp_valid[1] && w < 10) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (rsp_valid[1] !== 1'b1) begin
            errors++;
            $display("FAIL bp_wait: got rv=%b expected rv[1]=1 within 10 cycles", rsp_valid);
        end
        b = rk(1);
        checks++;
        if (b !== ks(k1, 1'b0)) begin
            errors++;
            $display("FAIL bp_bundle: got %h expected %h", b, ks(k1, 1'b0));
        end
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if (rsp_valid[1] !== 1'b1 || rk(1) !== b || req_ready[1] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold c=%0d: got rv1=%b rdy1=%b stable=%b expected 1 0 1", c, rsp_valid[1], req_ready[1], rk(1) === b);
            end
            if (req_ready[0]) g0++;
            @(negedge clk);
        end
        checks++;
        if (g0 < 2) begin
            errors++;
            $display("FAIL bp_progress: got %0d grants to req0 expected >=2", g0);
        end
        rsp_ready[1] = 1;
        #1;
        checks++;
        if (req_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL bp_same_cycle: got rdy1=%b expected 0", req_ready[1]);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got rv1=%b expected 0", rsp_valid[1]);
        end
        req_valid = '0;
        rsp_ready = '1;
        repeat (6) @(negedge clk);
        rsp_ready = '0;
    endtask

    task automatic test_random(input int lsel, input int ncyc);
        pend_t q[$];
        pend_t p;
        bit out [N];
        bit held [N];
        logic [767:0] hrk [N];
        logic [63:0] pool [4];
        logic [N-1:0] erv;
        logic [63:0] ekk = '0;
        logic edk = 0;
        bit ekv = 0;
        int ptr = 0, g;
        do_reset();
        lat = lsel;
        for (int i = 0; i < N; i++) begin
            out[i] = 0;
            held[i] = 0;
            hrk[i] = '0;
        end
        for (int i = 0; i < 4; i++) pool[i] = {$urandom, $urandom};
        for (int c = 0; c < ncyc; c++) begin
            while (q.size() > 0 && q[0].due == c) begin
                held[q[0].id] = 1;
                hrk[q[0].id] = q[0].rk;
                q.delete(0);
            end
            req_valid = N'($urandom);
            req_dec = N'($urandom);
            rsp_ready = N'($urandom);
            for (int i = 0; i < N; i++) begin
`ifdef DES_KEY_ARB_CACHE_EN
                req_key[64*i +: 64] = {$urandom, $urandom};
`else
                req_key[64*i +: 64] = pool[$urandom_range(0, 3)];
`endif
            end
            #1;
            erv = '0;
            for (int i = 0; i < N; i++) erv[i] = held[i];
            checks++;
            if (rsp_valid !== erv) begin
                errors++;
                $display("FAIL rnd_rv c=%0d: got %b expected %b", c, rsp_valid, erv);
            end
            for (int i = 0; i < N; i++) begin
                if (held[i]) begin
                    checks++;
                    if (rk(i) !== hrk[i]) begin
                        errors++;
                        $display("FAIL rnd_rk c=%0d req%0d: got %h expected %h", c, i, rk(i), hrk[i]);
                    end
                end
            end
            checks++;
            if (kg_valid !== ekv || (ekv && (kg_key !== ekk || kg_dec !== edk))) begin
                errors++;
                $display("FAIL rnd_kg c=%0d: got v=%b key=%h dec=%b expected v=%b key=%h dec=%b", c, kg_valid, kg_key, kg_dec, ekv, ekk, edk);
            end
            checks++;
            if (busy !== ((|erv) || q.size() > 0) || err !== 1'b0) begin
                errors++;
                $display("FAIL rnd_busy c=%0d: got busy=%b err=%b expected busy=%b err=0", c, busy, err, (|erv) || q.size() > 0);
            end
            g = -1;
            for (int k = 0; k < N; k++) if (g < 0 && req_valid[(ptr + k) % N] && !out[(ptr + k) % N]) g = (ptr + k) % N;
            checks++;
            if (req_ready !== ((g < 0) ? N'(0) : (N'(1) << g))) begin
                errors++;
                $display("FAIL rnd_grant c=%0d: got %b expected winner %0d", c, req_ready, g);
            end
            ekv = g >= 0;
            if (g >= 0) begin
                ekk = req_key[64*g +: 64];
                edk = req_dec[g];
                out[g] = 1;
                ptr = (g + 1) % N;
                p.id = g;
                p.due = c + lat + 2;
                p.rk = ks(ekk, edk);
                q.push_back(p);
            end
            for (int i = 0; i < N; i++) begin
                if (held[i] && rsp_ready[i]) begin
                    held[i] = 0;
                    out[i] = 0;
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = '1;
        repeat (lat + 4) @(negedge clk);
        rsp_ready = '0;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        lat = 3;
        for (int i = 0; i < N; i++) req_key[64*i +: 64] = {$urandom, $urandom};
        req_dec = '0;
        req_valid = '1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || kg_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_inflight: got busy=%b kgv=%b expected 1 1", busy, kg_valid);
        end
        #2 rst = 1;
        #1;
        checks++;
        if ({req_ready, kg_valid, kg_dec, kg_key, rsp_valid, busy, err} !== '0 || rsp_round_keys !== '0) begin
            errors++;
            $display("FAIL mid_async: got %h expected 0", {req_ready, kg_valid, kg_dec, kg_key, rsp_valid, busy, err});
        end
        @(negedge clk);
        req_valid = '0;
        rst = 0;
        repeat (6) @(negedge clk);
        checks++;
        if (rsp_valid !== '0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL mid_quiet: got rv=%b busy=%b err=%b expected 00 0 0", rsp_valid, busy, err);
        end
        inj = 1;
        @(negedge clk);
        inj = 0;
        checks++;
        if (err !== 1'b1 || rsp_valid !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_err: got err=%b rv=%b busy=%b expected 1 00 0", err, rsp_valid, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b expected 1", err);
        end
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b expected 0", err);
        end
    endtask

`ifdef DES_KEY_ARB_CACHE_EN
    task automatic test_cache();
        logic [63:0] k = {$urandom, $urandom};
        logic [767:0] b;
        do_reset();
        lat = 1;
        req_key[63:0] = k;
        req_dec[0] = 0;
        req_valid[0] = 1;
        @(negedge clk);
        req_valid[0] = 0;
        repeat (2) @(negedge clk);
        b = rk(0);
        checks++;
        if (rsp_valid !== 2'b01 || b !== ks(k, 1'b0)) begin
            errors++;
            $display("FAIL cache_fill: got rv=%b bundle=%h expected 01 %h", rsp_valid, b, ks(k, 1'b0));
        end
        rsp_ready[0] = 1;
        @(negedge clk);
        rsp_ready[0] = 0;
        req_valid[0] = 1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL cache_grant: got %b expected 01", req_ready);
        end
        @(negedge clk);
        req_valid[0] = 0;
        checks++;
        if (kg_valid !== 1'b0 || rsp_valid !== 2'b01 || rk(0) !== b) begin
            errors++;
            $display("FAIL cache_hit: got kgv=%b rv=%b same=%b expected 0 01 1", kg_valid, rsp_valid, rk(0) === b);
        end
        rsp_ready[0] = 1;
        @(negedge clk);
        rsp_ready[0] = 0;
        req_dec[0] = 1;
        req_valid[0] = 1;
        @(negedge clk);
        req_valid[0] = 0;
        checks++;
        if (kg_valid !== 1'b1 || rsp_valid !== '0) begin
            errors++;
            $display("FAIL cache_miss: got kgv=%b rv=%b expected 1 00", kg_valid, rsp_valid);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b01 || rk(0) !== ks(k, 1'b1)) begin
            errors++;
            $display("FAIL cache_mode: got rv=%b bundle=%h expected 01 %h", rsp_valid, rk(0), ks(k, 1'b1));
        end
        rsp_ready[0] = 1;
        @(negedge clk);
        rsp_ready[0] = 0;
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single(1'b0);
        test_single(1'b1);
        test_fairness();
        test_backpressure();
        test_random(1, 250);
        test_random(3, 250);
        test_reset_midflight();
`ifdef DES_KEY_ARB_CACHE_EN
        test_cache();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
